// File: rtl/exec_redirect_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exec_redirect_pkg
//  Description : Shared types and constants for the execute-stage redirect
//                unit (branch funct3 encodings, FSM states, default width).
//  Revision    : 1.0 - initial release
// ============================================================================
package exec_redirect_pkg;

    localparam int unsigned c_xlen_default = 32;

    // Branch funct3 encodings; 010 and 011 are reserved and never taken.
    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_op_e;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } redir_state_e;

endpackage
`default_nettype wire

// File: rtl/exec_redirect_if.sv
`default_nettype none
// ============================================================================
//  Module      : exec_redirect_if
//  Description : EX-stage resolution inputs and fetch-stage redirect outputs.
//                The slave modport is the redirect unit; the master modport
//                is the surrounding pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
interface exec_redirect_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic             ex_is_branch;
    logic             ex_is_jal;
    logic             ex_is_jalr;
    logic [2:0]       ex_br_op;
    logic [XLEN-1:0]  ex_rs1;
    logic [XLEN-1:0]  ex_rs2;
    logic [XLEN-1:0]  ex_imm;
    logic             stall_req;

    logic             pc_src;
    logic             jalr_flag;
    logic [XLEN-1:0]  jalr_target_offset;
    logic [XLEN-1:0]  branch_target;
    logic             pc_write;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             exc_misaligned;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        output ex_valid, ex_pc, ex_is_branch, ex_is_jal, ex_is_jalr,
               ex_br_op, ex_rs1, ex_rs2, ex_imm, stall_req,
        input  pc_src, jalr_flag, jalr_target_offset, branch_target,
               pc_write, flush_if_id, flush_id_ex, exc_misaligned,
               redirect_cnt
    );

    modport slave (
        input  ex_valid, ex_pc, ex_is_branch, ex_is_jal, ex_is_jalr,
               ex_br_op, ex_rs1, ex_rs2, ex_imm, stall_req,
        output pc_src, jalr_flag, jalr_target_offset, branch_target,
               pc_write, flush_if_id, flush_id_ex, exc_misaligned,
               redirect_cnt
    );
endinterface
`default_nettype wire

// File: rtl/exec_redirect_branch_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : branch_cmp
//  Description : Combinational branch condition evaluation from funct3.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_cmp
    import exec_redirect_pkg::*;
#(
    parameter int XLEN = c_xlen_default
) (
    input  wire logic [XLEN-1:0] rs1,
    input  wire logic [XLEN-1:0] rs2,
    input  wire logic [2:0]      br_op,
    output logic                 taken
);

    // Decode funct3 into a condition; reserved encodings fall through to 0.
    always_comb begin
        taken = 1'b0;
        case (br_op_e'(br_op))
            BR_EQ:   taken = (rs1 == rs2);
            BR_NE:   taken = (rs1 != rs2);
            BR_LT:   taken = ($signed(rs1) <  $signed(rs2));
            BR_GE:   taken = ($signed(rs1) >= $signed(rs2));
            BR_LTU:  taken = (rs1 <  rs2);
            BR_GEU:  taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/exec_redirect.sv
`default_nettype none
// ============================================================================
//  Module      : exec_redirect
//  Description : Resolves control transfers in EX, issues a one-cycle
//                registered redirect with pipeline flushes, merges the
//                load-use stall into pc_write and counts redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_redirect
    import exec_redirect_pkg::*;
#(
    parameter int XLEN  = c_xlen_default,
    parameter int CNT_W = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    exec_redirect_if.slave bus
);

    redir_state_e     r_state;
    redir_state_e     w_state_next;
    logic             r_run;
    logic             r_jalr_flag;
    logic [XLEN-1:0]  r_jalr_tgt;
    logic [XLEN-1:0]  r_br_tgt;
    logic             r_exc;
    logic [CNT_W-1:0] r_cnt;

    logic             w_br_taken;
    logic [XLEN-1:0]  w_br_tgt;
    logic [XLEN-1:0]  w_jalr_tgt;
    logic             w_taken;
    logic             w_resolve;
    logic             w_misaligned;
    logic             w_redirect;

    branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
        .rs1   (bus.ex_rs1),
        .rs2   (bus.ex_rs2),
        .br_op (bus.ex_br_op),
        .taken (w_br_taken)
    );

    assign w_br_tgt     = bus.ex_pc + bus.ex_imm;
    assign w_jalr_tgt   = (bus.ex_rs1 + bus.ex_imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
    assign w_taken      = bus.ex_is_jal | bus.ex_is_jalr
                        | (bus.ex_is_branch & w_br_taken);
    // Instructions seen during REDIRECT are wrong-path and never resolve.
    assign w_resolve    = (r_state == IDLE) & bus.ex_valid & w_taken;
    assign w_misaligned = bus.ex_is_jalr ? w_jalr_tgt[1] : w_br_tgt[1];
    assign w_redirect   = w_resolve & ~w_misaligned;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next state: REDIRECT lasts exactly one cycle.
    always_comb begin
        w_state_next = IDLE;
        case (r_state)
            IDLE:     w_state_next = w_redirect ? REDIRECT : IDLE;
            REDIRECT: w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    // Capture targets on redirect; report misalignment for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_jalr_flag <= 1'b0;
            r_jalr_tgt  <= '0;
            r_br_tgt    <= '0;
            r_exc       <= 1'b0;
        end else begin
            r_exc <= w_resolve & w_misaligned;
            if (w_redirect) begin
                r_jalr_flag <= bus.ex_is_jalr;
                r_jalr_tgt  <= w_jalr_tgt;
                r_br_tgt    <= w_br_tgt;
            end
        end
    end

    // Saturating redirect counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           r_cnt <= '0;
        else if (w_redirect && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end

    // Holds pc_write low while in reset and for the cycle of deassertion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_run <= 1'b0;
        else     r_run <= 1'b1;
    end

    assign bus.pc_src             = (r_state == REDIRECT);
    assign bus.flush_if_id        = (r_state == REDIRECT);
    assign bus.flush_id_ex        = (r_state == REDIRECT);
    assign bus.pc_write           = r_run & ((r_state == REDIRECT) | ~bus.stall_req);
    assign bus.jalr_flag          = r_jalr_flag;
    assign bus.jalr_target_offset = r_jalr_tgt;
    assign bus.branch_target      = r_br_tgt;
    assign bus.exc_misaligned     = r_exc;
    assign bus.redirect_cnt       = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_exec_redirect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_redirect
//  Description : Scoreboard bench for exec_redirect: directed cases followed
//                by random instruction streams against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_redirect;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    typedef struct {
        logic             pc_src;
        logic             jflag;
        logic [XLEN-1:0]  jt;
        logic [XLEN-1:0]  bt;
        logic             exc;
        logic [CNT_W-1:0] cnt;
        logic             pw;
    } exp_t;

    logic clk;
    logic rst;
    exec_redirect_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    exec_redirect #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: what the fetch stage should observe this cycle.
    logic             m_redir, m_jflag, m_exc, m_run;
    logic [XLEN-1:0]  m_jt, m_bt;
    logic [CNT_W-1:0] m_cnt;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic cond(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int signed sa, sb;
        sa = a; sb = b;
        case (op)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return sa < sb;
            3'b101: return sa >= sb;
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_redir = 0; m_jflag = 0; m_exc = 0; m_run = 0;
        m_jt = '0; m_bt = '0; m_cnt = '0;
    endtask

    // Apply one EX-stage cycle; push what the outputs must show during it.
    task automatic drive(input logic v, input logic br, input logic jal, input logic jalr,
                         input logic [2:0] op, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] imm, input logic stall);
        exp_t e;
        logic tk;
        logic [XLEN-1:0] tgt;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.ex_valid = v; bus.ex_is_branch = br; bus.ex_is_jal = jal; bus.ex_is_jalr = jalr;
        bus.ex_br_op = op; bus.ex_pc = pc; bus.ex_rs1 = a; bus.ex_rs2 = b; bus.ex_imm = imm;
        bus.stall_req = stall;
        e.pc_src = m_redir; e.jflag = m_jflag; e.jt = m_jt; e.bt = m_bt;
        e.exc = m_exc; e.cnt = m_cnt; e.pw = m_run & (m_redir | ~stall);
        q.push_back(e);
        tk  = v && !m_redir && (jal || jalr || (br && cond(op, a, b)));
        tgt = jalr ? ((a + imm) & ~32'd1) : (pc + imm);
        m_run = 1'b1;
        m_exc = 1'b0;
        if (tk && tgt[1]) begin
            m_exc = 1'b1; m_redir = 1'b0;
        end else if (tk) begin
            m_redir = 1'b1;
            m_jflag = jalr;
            m_jt = (a + imm) & ~32'd1;
            m_bt = pc + imm;
            if (m_cnt != c_cnt_max) m_cnt = m_cnt + 1'b1;
        end else begin
            m_redir = 1'b0;
        end
    endtask

    task automatic bubble(input logic stall);
        drive(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, stall);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".pc_src"},   {31'b0, bus.pc_src},      32'h0);
        chk({tag, ".flush"},    {30'b0, bus.flush_if_id, bus.flush_id_ex}, 32'h0);
        chk({tag, ".pc_write"}, {31'b0, bus.pc_write},    32'h0);
        chk({tag, ".jflag"},    {31'b0, bus.jalr_flag},   32'h0);
        chk({tag, ".jt"},       bus.jalr_target_offset,   32'h0);
        chk({tag, ".bt"},       bus.branch_target,        32'h0);
        chk({tag, ".exc"},      {31'b0, bus.exc_misaligned}, 32'h0);
        chk({tag, ".cnt"},      {26'b0, bus.redirect_cnt}, 32'h0);
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pc_src",   {31'b0, bus.pc_src},      {31'b0, e.pc_src});
                chk("flush_if", {31'b0, bus.flush_if_id}, {31'b0, e.pc_src});
                chk("flush_ex", {31'b0, bus.flush_id_ex}, {31'b0, e.pc_src});
                chk("pc_write", {31'b0, bus.pc_write},    {31'b0, e.pw});
                chk("exc",      {31'b0, bus.exc_misaligned}, {31'b0, e.exc});
                chk("cnt",      {26'b0, bus.redirect_cnt}, {26'b0, e.cnt});
                chk("jflag",    {31'b0, bus.jalr_flag},   {31'b0, e.jflag});
                chk("jalr_tgt", bus.jalr_target_offset,   e.jt);
                chk("br_tgt",   bus.branch_target,        e.bt);
            end
        end
    end

    initial begin
        logic [2:0] op;
        int kind;
        logic [XLEN-1:0] a, b;
        rst = 1'b0;
        bus.ex_valid = 0; bus.ex_is_branch = 0; bus.ex_is_jal = 0; bus.ex_is_jalr = 0;
        bus.ex_br_op = 0; bus.ex_pc = 0; bus.ex_rs1 = 0; bus.ex_rs2 = 0; bus.ex_imm = 0;
        bus.stall_req = 0;
        model_reset();
        #1 rst = 1'b1;
        #1 chk_all_zero("reset");

        // Directed cases.
        drive(1, 1, 0, 0, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 0);          // BEQ taken
        bubble(1);                                                             // stall in REDIRECT
        drive(1, 1, 0, 0, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 0);   // BLTU not taken
        drive(1, 1, 0, 0, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 0);   // BLT taken
        bubble(0);
        drive(1, 0, 0, 1, 3'b000, 32'h300, 32'h1001, 32'h0, 32'd4, 0);         // JALR 0x1004
        bubble(0);
        drive(1, 0, 0, 1, 3'b000, 32'h300, 32'h1002, 32'h0, 32'd0, 0);         // JALR misaligned
        bubble(1);                                                             // stall, no branch
        drive(1, 1, 0, 0, 3'b010, 32'h400, 32'd1, 32'd1, 32'h8, 0);            // reserved op
        drive(1, 0, 1, 0, 3'b000, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h20, 0);     // JAL wraps to 0x10
        drive(1, 0, 1, 0, 3'b000, 32'h500, 32'h0, 32'h0, 32'h100, 0);          // ignored in REDIRECT
        bubble(0);
        drive(1, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1);

        // Asynchronous reset in the middle of a REDIRECT cycle.
        drive(1, 0, 1, 0, 3'b000, 32'h600, 32'h0, 32'h0, 32'h40, 0);
        @(posedge clk); #1;
        bus.ex_valid = 0;
        chk("mid.pc_src", {31'b0, bus.pc_src}, 32'h1);
        #2 rst = 1'b1;
        #1 chk_all_zero("mid_redirect_rst");
        model_reset();
        bubble(0);                                                             // rst drops here
        bubble(0);

        // Random streams; counter saturation arrives naturally.
        for (int i = 0; i < 3000; i++) begin
            kind = $urandom_range(0, 9);
            op   = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3)) - 32'd1;
            drive($urandom_range(0, 4) != 0,
                  kind < 5, kind == 5 || kind == 6, kind == 7,
                  op, {$urandom} & 32'hFFFF_FFFC, a, b,
                  {$urandom} & (($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC),
                  $urandom_range(0, 3) == 0);
        end
        bubble(0);
        @(posedge clk);
        @(negedge clk); #1;
        chk("queue_drained", 32'(q.size()), 32'h0);
        chk("cnt_saturated", {26'b0, bus.redirect_cnt}, {26'b0, c_cnt_max});
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exec_redirect.md
# exec_redirect

Execute-stage control-transfer resolution unit that drives the fetch stage's redirect interface (`pc_src`, `jalr_flag`, `jalr_target_offset`, `pc_write`). It evaluates branch conditions and jump targets for the instruction in EX and issues a one-cycle registered redirect with pipeline flushes. It also merges the decode-stage load-use stall into `pc_write` and keeps a saturating redirect counter. Fetch predicts not-taken; this block is the sole source of PC redirection.

## Interface
- `XLEN`, 32, data/address width
- `CNT_W`, 16, width of redirect counter

- `clk` in 1 system clock, rising edge
- `rst` in 1 asynchronous, active-high reset
- `ex_valid` in 1 EX holds a real instruction
- `ex_pc` in XLEN PC of EX instruction
- `ex_is_branch` / `ex_is_jal` / `ex_is_jalr` in 1 each, one-hot or all zero
- `ex_br_op` in 3 branch funct3
- `ex_rs1`, `ex_rs2`, `ex_imm` in XLEN forwarded operands, sign-extended immediate
- `stall_req` in 1 load-use stall request from ID
- `pc_src` out 1 fetch takes redirect target this cycle
- `jalr_flag` out 1 target is `jalr_target_offset`, else `branch_target`
- `jalr_target_offset` out XLEN (rs1+imm) with bit 0 cleared
- `branch_target` out XLEN pc+imm
- `pc_write` out 1 PC update enable (0 = hold)
- `flush_if_id`, `flush_id_ex` out 1 clear pipeline registers at next edge
- `exc_misaligned` out 1 taken target has bit 1 set
- `redirect_cnt` out CNT_W number of redirects issued

## Operation
- Taken condition: branch with condition true; `ex_is_jal`; `ex_is_jalr`. Only evaluated when `ex_valid`=1 and state IDLE.
- `ex_br_op`: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 → not taken, no error.
- Target arithmetic modulo 2^XLEN (wraps, no overflow flag). JALR: bit 0 cleared before misalignment check.
- Misaligned taken target (bit 1 = 1): no redirect, `exc_misaligned`=1 one cycle, state stays IDLE, counter unchanged.
- FSM states IDLE, REDIRECT.
  - IDLE → REDIRECT on aligned taken resolution; targets, `jalr_flag` registered.
  - REDIRECT: `pc_src`=1, `flush_if_id`=1, `flush_id_ex`=1 for exactly one cycle; EX inputs ignored (wrong-path); always → IDLE.
- Back-to-back: instruction in EX the cycle after REDIRECT is evaluated normally (it is a flushed bubble with `ex_valid`=0 in correct pipelines).
- `pc_write` = 0 when `stall_req`=1 in IDLE; forced 1 in REDIRECT (redirect wins over stall). While stalled, EX resolution still evaluated.
- `redirect_cnt` increments on each IDLE→REDIRECT, saturates at all ones.

## Timing
- Resolution in cycle N → `pc_src`, flushes, targets valid in N+1 (1-cycle registered latency); fetch loads target at end of N+1.
- `pc_write` is combinational from `stall_req` and state (same cycle).
- `jalr_target_offset`, `branch_target`, `jalr_flag` hold last registered value outside REDIRECT.
- Reset (asynchronous, any cycle incl. mid-REDIRECT): state IDLE; all outputs 0 including `pc_write`, `redirect_cnt`; after deassertion `pc_write` follows `stall_req` next cycle.

## Structure
- Package `exec_redirect_pkg`: `br_op_e` enum (funct3 encodings), `redir_state_e` {IDLE, REDIRECT}, `XLEN` default constant.
- Sub-module `branch_cmp`: combinational (`rs1`, `rs2`, `br_op`) → `taken`.
- Top holds FSM, target adders, output registers, counter.

## Test plan
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20 → N+1: `pc_src`=1, `jalr_flag`=0, `branch_target`=0x120, both flushes 1 for one cycle, `redirect_cnt`=1.
- BLTU rs1=0xFFFF_FFFF, rs2=1 → not taken; BLT same operands → taken (signed −1<1).
- JALR rs1=0x1001, imm=4 → `jalr_flag`=1, `jalr_target_offset`=0x1004; rs1=0x1002, imm=0 → `exc_misaligned`=1, `pc_src`=0.
- `stall_req`=1 with no branch → `pc_write`=0 same cycle; `stall_req`=1 during REDIRECT → `pc_write`=1.
- Taken JAL in two consecutive cycles → only first redirects; second ignored in REDIRECT; pc=0xFFFF_FFF0, imm=0x20 → target 0x10 (wrap).
- Force `redirect_cnt` to 0xFFFF, redirect → stays 0xFFFF; assert `rst` mid-REDIRECT → all outputs 0 immediately.
